snoopy_tag_directory: RTL

//  Parametrised tag/state directory for the set-associative snoopy cache. Dual lookup (CPU, snoopy),
//  one update port, one invalidate port, tree pseudo-LRU victim selection, self-initialising

---
 rtl/snoopy_tag_directory.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/snoopy_tag_directory.sv
// Tag/state directory for a set-associative snoopy cache: CPU and snoop lookups, update/touch and
// invalidate ports, tree PLRU victims, post-reset sweep. Macro TAG_DIRECTORY_FORWARDING_EN.
module snoopy_tag_directory #(
  parameter int unsigned            TAG_WIDTH      = 6,
  parameter int unsigned            INDEX_WIDTH    = 6,
  parameter int unsigned            NUMBER_OF_WAYS = 4,
  parameter int unsigned            STATE_WIDTH    = 2,
  parameter logic [STATE_WIDTH-1:0] INVALID_STATE  = '0,
  localparam int unsigned           WAY_WIDTH      = $clog2(NUMBER_OF_WAYS)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   cpuValid,
  input  logic [INDEX_WIDTH-1:0] cpuIndex,
  input  logic [TAG_WIDTH-1:0]   cpuTag,
  output logic                   cpuResponseValid,
  output logic                   cpuHit,
  output logic [WAY_WIDTH-1:0]   cpuWay,
  output logic [STATE_WIDTH-1:0] cpuState,
  output logic [WAY_WIDTH-1:0]   victimWay,
  input  logic                   snoopValid,
  input  logic [INDEX_WIDTH-1:0] snoopIndex,
  input  logic [TAG_WIDTH-1:0]   snoopTag,
  output logic                   snoopResponseValid,
  output logic                   snoopHit,
  output logic [WAY_WIDTH-1:0]   snoopWay,
  output logic [STATE_WIDTH-1:0] snoopState,
  input  logic                   updateEnable,
  input  logic                   touchEnable,
  input  logic [INDEX_WIDTH-1:0] updateIndex,
  input  logic [WAY_WIDTH-1:0]   updateWay,
  input  logic [TAG_WIDTH-1:0]   updateTag,
  input  logic [STATE_WIDTH-1:0] updateState,
  input  logic                   invalidateEnable,
  input  logic [INDEX_WIDTH-1:0] invalidateIndex,
  input  logic [WAY_WIDTH-1:0]   invalidateWay
);

  localparam int unsigned NumSets = 1 << INDEX_WIDTH;

  typedef logic [NUMBER_OF_WAYS-1:0][TAG_WIDTH-1:0]   tagRowT;
  typedef logic [NUMBER_OF_WAYS-1:0][STATE_WIDTH-1:0] stateRowT;
  typedef logic [NUMBER_OF_WAYS-2:0]                  plruRowT;

  typedef struct packed {
    logic                   multi;
    logic                   hit;
    logic [WAY_WIDTH-1:0]   way;
    logic [STATE_WIDTH-1:0] state;
  } lookupT;

  typedef enum logic [0:0] {StInit, StReady} fsmStateT;

  fsmStateT               fsmQ, fsmD;
  logic [INDEX_WIDTH-1:0] sweepQ, sweepD;

  tagRowT   tagMem   [NumSets];
  stateRowT stateMem [NumSets];
  plruRowT  plruMem  [NumSets];

  tagRowT         cpuTags, snoopTags;
  stateRowT       cpuStates, snoopStates;
  plruRowT        cpuPlru;
  lookupT         cpuLook, snoopLook;
  logic [WAY_WIDTH-1:0] cpuVictim;

  // Tree nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic int unsigned nodeOf(input int unsigned way, input int unsigned level);
    return ((32'd1 << level) - 32'd1) + (way >> (WAY_WIDTH - level));
  endfunction

  function automatic logic wayDir(input int unsigned way, input int unsigned level);
    return ((way >> (WAY_WIDTH - 1 - level)) & 32'd1) != 32'd0;
  endfunction

  function automatic logic [WAY_WIDTH-1:0] plruVictim(input plruRowT bits);
    logic [WAY_WIDTH-1:0] victim;
    logic                 onPath;
    victim = '0;
    for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
      onPath = 1'b1;
      for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
        if (bits[nodeOf(w, l)] != wayDir(w, l)) begin
          onPath = 1'b0;
        end
      end
      if (onPath) begin
        victim = WAY_WIDTH'(w);
      end
    end
    return victim;
  endfunction

  function automatic plruRowT plruTouch(input plruRowT bits, input logic [WAY_WIDTH-1:0] way);
    plruRowT next;
    next = bits;
    for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (way == WAY_WIDTH'(w)) begin
        for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
          next[nodeOf(w, l)] = !wayDir(w, l);
        end
      end
    end
    return next;
  endfunction

  function automatic logic [WAY_WIDTH-1:0] victimSelect(input stateRowT states,
                                                        input plruRowT bits);
    logic [WAY_WIDTH-1:0] victim;
    victim = plruVictim(bits);
    // Descending scan so the lowest-numbered invalid way is the one left standing.
    for (int w = NUMBER_OF_WAYS - 1; w >= 0; w--) begin
      if (states[w] == INVALID_STATE) begin
        victim = WAY_WIDTH'(w);
      end
    end
    return victim;
  endfunction

  function automatic lookupT lookupRow(input tagRowT tags, input stateRowT states,
                                       input logic [TAG_WIDTH-1:0] tag);
    lookupT res;
    res       = '0;
    res.state = INVALID_STATE;
    for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (tags[w] == tag && states[w] != INVALID_STATE) begin
        res.multi = res.multi | res.hit;
        res.hit   = 1'b1;
        res.way   = WAY_WIDTH'(w);
        res.state = states[w];
      end
    end
    return res;
  endfunction

  assign ready = (fsmQ == StReady);

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsmQ   <= StInit;
      sweepQ <= '0;
    end else begin
      fsmQ   <= fsmD;
      sweepQ <= sweepD;
    end
  end

  always_comb begin
    fsmD   = fsmQ;
    sweepD = sweepQ;
    unique case (fsmQ)
      StInit: begin
        sweepD = sweepQ + 1'b1;
        if (sweepQ == {INDEX_WIDTH{1'b1}}) begin
          fsmD = StReady;
        end
      end
      StReady: fsmD = StReady;
      default: fsmD = StInit;
    endcase
  end

  // Arrays have no reset of their own; the sweep establishes a clean directory.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (fsmQ == StInit) begin
        stateMem[sweepQ] <= {NUMBER_OF_WAYS{INVALID_STATE}};
        plruMem[sweepQ]  <= '0;
      end else begin
        if (updateEnable) begin
          tagMem[updateIndex][updateWay]   <= updateTag;
          stateMem[updateIndex][updateWay] <= updateState;
        end
        if (updateEnable || touchEnable) begin
          plruMem[updateIndex] <= plruTouch(plruMem[updateIndex], updateWay);
        end
        // Placed after the update so a collision on the same way leaves it invalid.
        if (invalidateEnable) begin
          stateMem[invalidateIndex][invalidateWay] <= INVALID_STATE;
        end
      end
    end
  end

  always_comb begin
    cpuTags     = tagMem[cpuIndex];
    cpuStates   = stateMem[cpuIndex];
    cpuPlru     = plruMem[cpuIndex];
    snoopTags   = tagMem[snoopIndex];
    snoopStates = stateMem[snoopIndex];
`ifdef TAG_DIRECTORY_FORWARDING_EN
    if (updateEnable && updateIndex == cpuIndex) begin
      cpuTags[updateWay]   = updateTag;
      cpuStates[updateWay] = updateState;
    end
    if ((updateEnable || touchEnable) && updateIndex == cpuIndex) begin
      cpuPlru = plruTouch(cpuPlru, updateWay);
    end
    if (invalidateEnable && invalidateIndex == cpuIndex) begin
      cpuStates[invalidateWay] = INVALID_STATE;
    end
    if (updateEnable && updateIndex == snoopIndex) begin
      snoopTags[updateWay]   = updateTag;
      snoopStates[updateWay] = updateState;
    end
    if (invalidateEnable && invalidateIndex == snoopIndex) begin
      snoopStates[invalidateWay] = INVALID_STATE;
    end
`endif
  end

  assign cpuLook   = lookupRow(cpuTags, cpuStates, cpuTag);
  assign snoopLook = lookupRow(snoopTags, snoopStates, snoopTag);
  assign cpuVictim = victimSelect(cpuStates, cpuPlru);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cpuResponseValid   <= 1'b0;
      cpuHit             <= 1'b0;
      cpuWay             <= '0;
      cpuState           <= '0;
      victimWay          <= '0;
      snoopResponseValid <= 1'b0;
      snoopHit           <= 1'b0;
      snoopWay           <= '0;
      snoopState         <= '0;
    end else begin
      cpuResponseValid   <= ready && cpuValid;
      snoopResponseValid <= ready && snoopValid;
      if (ready && cpuValid) begin
        assert (!cpuLook.multi);
        cpuHit    <= cpuLook.hit;
        cpuWay    <= cpuLook.way;
        cpuState  <= cpuLook.state;
        victimWay <= cpuVictim;
      end
      if (ready && snoopValid) begin
        assert (!snoopLook.multi);
        snoopHit   <= snoopLook.hit;
        snoopWay   <= snoopLook.way;
        snoopState <= snoopLook.state;
      end
    end
  end

endmodule
